// File: rtl/pipeline_pkg.sv
// Shared pipeline types: 2-bit direction counter, BTB entry layout, saturating counter step.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pipeline_pkg;

    localparam int BP_PC_W  = 5;
    localparam int BP_IDX_W = 3;
    localparam int BP_TAG_W = BP_PC_W - BP_IDX_W;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_PC_W-1:0]  target;
        ctr_t                ctr;
    } btb_entry_t;

    // Saturating 2-bit step: up on taken (stops at ST), down on not-taken (stops at SNT).
    function automatic ctr_t ctr_next(ctr_t c, logic taken);
        ctr_t r;
        r = c;
        if (taken) begin
            if (c != CTR_ST) r = c + 2'b01;
        end else begin
            if (c != CTR_SNT) r = c - 2'b01;
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_stat_counter.sv
// Saturating event counter: counts cycles with inc_i high, sticks at all-ones.
// Latency: count visible one cycle after the counted event.
// Backpressure: none; one event per cycle at most.
module bp_stat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // Count up on each event, never wrap past all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc_i && !(&count_q)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/branch_prediction_unit.sv
// Tagged direct-mapped BTB with 2-bit counters; fetch lookup, execute-stage training, stats.
// Latency: lookup combinational (0 cycles); training visible the cycle after the update edge.
// Backpressure: none; the pipeline drops update_signal_E on bubbles instead of stalling us.
module branch_prediction_unit
    import pipeline_pkg::*;
#(
    parameter int PC_W  = BP_PC_W,
    parameter int IDX_W = BP_IDX_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc_F,
    output logic             prediction_F,
    output logic [PC_W-1:0]  target_F,
    output logic             btb_hit_F,
    input  logic             update_signal_E,
    input  logic [PC_W-1:0]  pc_E,
    input  logic             actual_outcome_E,
    input  logic             prediction_E,
    input  logic [PC_W-1:0]  target_E,
    output logic             mispredict_E,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;

    btb_entry_t btb_q [ENTRIES];

    logic [IDX_W-1:0] idx_F;
    logic [IDX_W-1:0] idx_E;
    logic [TAG_W-1:0] tag_F;
    logic [TAG_W-1:0] tag_E;
    btb_entry_t       entry_F;
    btb_entry_t       entry_E;
    logic             hit_F;
    logic             hit_E;

    assign idx_F   = pc_F[IDX_W-1:0];
    assign tag_F   = pc_F[PC_W-1:IDX_W];
    assign idx_E   = pc_E[IDX_W-1:0];
    assign tag_E   = pc_E[PC_W-1:IDX_W];
    assign entry_F = btb_q[idx_F];
    assign entry_E = btb_q[idx_E];

    assign hit_F = entry_F.valid && (entry_F.tag == tag_F);
    assign hit_E = entry_E.valid && (entry_E.tag == tag_E);

    // Lookup reads registered table contents only, so a same-cycle update is not bypassed.
    always_comb begin
        btb_hit_F    = 1'b0;
        prediction_F = 1'b0;
        target_F     = '0;
        if (!reset && hit_F) begin
            btb_hit_F    = 1'b1;
            prediction_F = entry_F.ctr[1];
            target_F     = entry_F.target;
        end
    end

    // Direction-only check: a tagged hit already carries the right target for a static branch.
    assign mispredict_E = !reset && update_signal_E && (prediction_E != actual_outcome_E);

    // Train the table from the resolved branch; reset wins over a pending update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else if (update_signal_E) begin
            if (hit_E) begin
                btb_q[idx_E].ctr <= ctr_next(entry_E.ctr, actual_outcome_E);
                if (actual_outcome_E) begin
                    btb_q[idx_E].target <= target_E;
                end
            end else if (actual_outcome_E) begin
                btb_q[idx_E] <= '{valid: 1'b1, tag: tag_E, target: target_E, ctr: CTR_WT};
            end
        end
    end

    bp_stat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (update_signal_E && !reset),
        .count_o (branch_count)
    );

    bp_stat_counter #(.W(CNT_W)) u_mispredict_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (mispredict_E),
        .count_o (mispredict_count)
    );

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Scoreboard bench for branch_prediction_unit: wide-counter instance plus a 2-bit-counter instance.
// Latency: expectations for each cycle are queued when inputs are driven, popped at the falling edge.
// Backpressure: n/a.
module tb_branch_prediction_unit;

    logic       clk;
    logic       reset;
    logic [4:0] pc_F;
    logic       update_signal_E;
    logic [4:0] pc_E;
    logic       actual_outcome_E;
    logic       prediction_E;
    logic [4:0] target_E;

    logic        prediction_F, btb_hit_F, mispredict_E;
    logic [4:0]  target_F;
    logic [15:0] branch_count, mispredict_count;

    logic        prediction_F2, btb_hit_F2, mispredict_E2;
    logic [4:0]  target_F2;
    logic [1:0]  branch_count2, mispredict_count2;

    branch_prediction_unit #(.PC_W(5), .IDX_W(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .pc_F(pc_F),
        .prediction_F(prediction_F), .target_F(target_F), .btb_hit_F(btb_hit_F),
        .update_signal_E(update_signal_E), .pc_E(pc_E), .actual_outcome_E(actual_outcome_E),
        .prediction_E(prediction_E), .target_E(target_E), .mispredict_E(mispredict_E),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_prediction_unit #(.PC_W(5), .IDX_W(3), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .pc_F(pc_F),
        .prediction_F(prediction_F2), .target_F(target_F2), .btb_hit_F(btb_hit_F2),
        .update_signal_E(update_signal_E), .pc_E(pc_E), .actual_outcome_E(actual_outcome_E),
        .prediction_E(prediction_E), .target_E(target_E), .mispredict_E(mispredict_E2),
        .branch_count(branch_count2), .mispredict_count(mispredict_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic        pred;
        logic [4:0]  tgt;
        logic        mis;
        logic [15:0] bc;
        logic [15:0] mc;
        logic [1:0]  bc2;
        logic [1:0]  mc2;
    } exp_t;

    exp_t exp_q[$];

    int n_checks;
    int n_fail;

    // Reference table, kept independently of the RTL.
    logic        m_valid [8];
    logic [1:0]  m_tag   [8];
    logic [4:0]  m_tgt   [8];
    int          m_ctr   [8];
    int          m_bc, m_mc, m_bc2, m_mc2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 2'd0; m_tgt[i] = 5'd0; m_ctr[i] = 1;
        end
        m_bc = 0; m_mc = 0; m_bc2 = 0; m_mc2 = 0;
    endtask

    // One cycle: drive inputs, queue expectations, compare at negedge, then advance the model.
    task automatic step(input logic rst, input logic [4:0] lpc, input logic upd,
                        input logic [4:0] epc, input logic taken, input logic pe,
                        input logic [4:0] etgt);
        exp_t e;
        exp_t o;
        int   fi, ei;
        logic mis;
        reset = rst; pc_F = lpc; update_signal_E = upd; pc_E = epc;
        actual_outcome_E = taken; prediction_E = pe; target_E = etgt;

        fi = int'(lpc % 8);
        e.hit  = !rst && m_valid[fi] && (m_tag[fi] == lpc[4:3]);
        e.pred = e.hit && (m_ctr[fi] >= 2);
        e.tgt  = e.hit ? m_tgt[fi] : 5'd0;
        mis    = !rst && upd && (pe != taken);
        e.mis  = mis;
        e.bc   = 16'(m_bc);
        e.mc   = 16'(m_mc);
        e.bc2  = 2'(m_bc2);
        e.mc2  = 2'(m_mc2);
        exp_q.push_back(e);

        @(negedge clk);
        o = exp_q.pop_front();
        check("hit",     32'(btb_hit_F),        32'(o.hit));
        check("pred",    32'(prediction_F),     32'(o.pred));
        check("target",  32'(target_F),         32'(o.tgt));
        check("mispred", 32'(mispredict_E),     32'(o.mis));
        check("bcount",  32'(branch_count),     32'(o.bc));
        check("mcount",  32'(mispredict_count), 32'(o.mc));
        check("bcount2", 32'(branch_count2),    32'(o.bc2));
        check("mcount2", 32'(mispredict_count2), 32'(o.mc2));
        check("hit2",    32'(btb_hit_F2),       32'(o.hit));

        if (rst) begin
            model_clear();
        end else if (upd) begin
            ei = int'(epc % 8);
            if (m_valid[ei] && m_tag[ei] == epc[4:3]) begin
                if (taken) begin
                    if (m_ctr[ei] < 3) m_ctr[ei]++;
                    m_tgt[ei] = etgt;
                end else if (m_ctr[ei] > 0) begin
                    m_ctr[ei]--;
                end
            end else if (taken) begin
                m_valid[ei] = 1'b1; m_tag[ei] = epc[4:3]; m_tgt[ei] = etgt; m_ctr[ei] = 2;
            end
            if (m_bc < 65535) m_bc++;
            if (m_bc2 < 3) m_bc2++;
            if (mis && m_mc < 65535) m_mc++;
            if (mis && m_mc2 < 3) m_mc2++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        model_clear();
        reset = 1'b1; pc_F = '0; update_signal_E = 1'b0; pc_E = '0;
        actual_outcome_E = 1'b0; prediction_E = 1'b0; target_E = '0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 0, 0);

        // Empty table: every PC misses, stats at zero.
        for (int p = 0; p < 32; p++) step(0, 5'(p), 0, 0, 0, 0, 0);

        // First taken branch at pc 6 allocates and mispredicts.
        step(0, 6, 1, 6, 1, 0, 2);
        check("tc2_bc_hard",  32'(m_bc), 32'd1);
        step(0, 6, 0, 0, 0, 0, 0);

        // Saturate upward, then walk back down.
        for (int k = 0; k < 3; k++) step(0, 6, 1, 6, 1, 1, 2);
        step(0, 6, 1, 6, 0, 1, 2);
        step(0, 6, 1, 6, 0, 1, 2);
        step(0, 6, 0, 0, 0, 0, 0);

        // Aliasing branch at pc 14 replaces the pc 6 entry.
        step(0, 6, 1, 14, 1, 0, 9);
        step(0, 6, 0, 0, 0, 0, 0);
        step(0, 14, 0, 0, 0, 0, 0);

        // Same-cycle lookup sees old contents; new contents appear next cycle.
        step(0, 14, 1, 14, 0, 1, 9);
        step(0, 14, 1, 14, 0, 0, 9);
        step(0, 14, 0, 0, 0, 0, 0);

        // Reset with an update in flight drops it and clears everything.
        step(1, 6, 1, 6, 1, 0, 4);
        step(0, 6, 0, 0, 0, 0, 0);
        step(0, 14, 0, 0, 0, 0, 0);

        // Five mispredictions: wide counter reaches 5, 2-bit counter sticks at 3.
        for (int k = 0; k < 5; k++) step(0, 3, 1, 3, 1, 0, 7);
        step(0, 3, 0, 0, 0, 0, 0);
        check("mc2_sat_final", 32'(mispredict_count2), 32'd3);
        check("mc_final",      32'(mispredict_count),  32'd5);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
